// File: rtl/bin_mult_sched.sv
// Wishbone-mapped job queue and shift-add multiplier sequencer with a single result register.
// Optional done interrupt output enabled by defining BIN_MULT_SCHED_IRQ_EN.
module bin_mult_sched #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          OP_W         = 8,
  parameter int          QDEPTH       = 4,
  parameter int          DAC_W        = 7
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [DAC_W-1:0] be_out,
`ifdef BIN_MULT_SCHED_IRQ_EN
  output logic             irq_done,
`endif
  output logic             busy
);

  localparam int PW = 2 * OP_W;
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam int NW = $clog2(OP_W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic              ack_reg;
  logic [31:0]       rdata_reg;
  logic [31:0]       rd_data;
  logic              enable_reg;
  logic              overflow_reg;
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic [PW-1:0]     job_mem [QDEPTH];
  logic [1:0]        state_reg;
  logic [PW-1:0]     a_reg;
  logic [OP_W-1:0]   b_reg;
  logic [PW-1:0]     acc_reg;
  logic [NW-1:0]     cnt_reg;
  logic [PW-1:0]     result_reg;
  logic              result_valid_reg;
  logic [DAC_W-1:0]  be_reg;
`ifdef BIN_MULT_SCHED_IRQ_EN
  logic              irq_en_reg;
  logic              irq_reg;
`endif

  logic       hit;
  logic       wr;
  logic       rd;
  logic [1:0] off;
  logic       full;
  logic       empty;
  logic       push_req;
  logic       push_ok;
  logic       pop;
  logic       flush;
  logic       writeback;
  logic       result_pop;
  logic [PW-1:0] job_head;
  logic       unused_ok;

  assign hit        = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDRESS[31:4]) & ~ack_reg;
  assign wr         = hit & wbs_we_i;
  assign rd         = hit & ~wbs_we_i;
  assign off        = wbs_adr_i[3:2];
  assign full       = (count_reg == CW'(QDEPTH));
  assign empty      = (count_reg == '0);
  assign push_req   = wr & (off == 2'd1);
  assign push_ok    = push_req & ~full;
  assign pop        = (state_reg == S_IDLE) & enable_reg & ~empty;
  assign flush      = wr & (off == 2'd0) & wbs_dat_i[1];
  assign writeback  = (state_reg == S_DONE) & ~result_valid_reg;
  assign result_pop = rd & (off == 2'd2) & result_valid_reg;
  assign job_head   = job_mem[rd_ptr_reg];

  // Byte selects and the low address bits carry no meaning: all accesses are full-word.
  assign unused_ok  = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = rdata_reg;
  assign be_out    = be_reg;
  assign busy      = (state_reg != S_IDLE);
`ifdef BIN_MULT_SCHED_IRQ_EN
  assign irq_done  = irq_reg;
`endif

  always_comb begin
    rd_data = '0;
    case (off)
      2'd0: begin
        rd_data[0] = enable_reg;
`ifdef BIN_MULT_SCHED_IRQ_EN
        rd_data[2] = irq_en_reg;
`endif
      end
      2'd2: begin
        if (result_valid_reg) begin
          rd_data[PW-1:0] = result_reg;
          rd_data[31]     = 1'b1;
        end
      end
      2'd3: begin
        rd_data[3:0] = 4'(count_reg);
        rd_data[8]   = result_valid_reg;
        rd_data[9]   = busy;
        rd_data[16]  = overflow_reg;
      end
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_reg      <= 1'b0;
      rdata_reg    <= '0;
      enable_reg   <= 1'b0;
      overflow_reg <= 1'b0;
`ifdef BIN_MULT_SCHED_IRQ_EN
      irq_en_reg   <= 1'b0;
`endif
    end else begin
      ack_reg   <= hit;
      rdata_reg <= rd ? rd_data : '0;
      if (wr && off == 2'd0) begin
        enable_reg <= wbs_dat_i[0];
`ifdef BIN_MULT_SCHED_IRQ_EN
        irq_en_reg <= wbs_dat_i[2];
`endif
      end
      if (push_req && full)
        overflow_reg <= 1'b1;
      else if (wr && off == 2'd3 && wbs_dat_i[16])
        overflow_reg <= 1'b0;
    end
  end

  // Queue storage needs no reset: only entries covered by count_reg are ever read.
  always_ff @(posedge wb_clk_i) begin
    if (push_ok)
      job_mem[wr_ptr_reg] <= {wbs_dat_i[OP_W+15:16], wbs_dat_i[OP_W-1:0]};
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push_ok) - CW'(pop);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg <= S_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (pop) begin
            a_reg     <= PW'(job_head[OP_W-1:0]);
            b_reg     <= job_head[PW-1:OP_W];
            state_reg <= S_LOAD;
          end
        end
        S_LOAD: begin
          acc_reg   <= '0;
          cnt_reg   <= NW'(OP_W);
          state_reg <= S_MUL;
        end
        S_MUL: begin
          // a_reg is pre-shifted each cycle so it always equals A << i.
          if (b_reg[0])
            acc_reg <= acc_reg + a_reg;
          a_reg   <= a_reg << 1;
          b_reg   <= b_reg >> 1;
          cnt_reg <= cnt_reg - NW'(1);
          if (cnt_reg == NW'(1))
            state_reg <= S_DONE;
        end
        S_DONE: begin
          if (!result_valid_reg)
            state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
      be_reg           <= '0;
    end else begin
      if (writeback) begin
        result_reg       <= acc_reg;
        result_valid_reg <= 1'b1;
        be_reg           <= acc_reg[PW-1 -: DAC_W];
      end else if (result_pop) begin
        result_valid_reg <= 1'b0;
      end
    end
  end

`ifdef BIN_MULT_SCHED_IRQ_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      irq_reg <= 1'b0;
    else
      irq_reg <= result_valid_reg & irq_en_reg;
  end
`endif

endmodule
